lsu_align: RTL and testbench

- Load/store alignment unit between the core's execute stage and Data_Memory.
- Accepts byte/half/word load/store requests at any byte address.
- Generates word-addressed memory accesses with byte write masks.
- Splits accesses that cross a 32-bit word boundary into two memory cycles; merges, shifts and sign/zero-extends load data before returning a single response.

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_extract.sv | 28 ++
 rtl/lsu_align.sv | 112 +++++++++++
 tb/tb_lsu_align.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store alignment unit.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC0,
        ST_ACC1,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
    } req_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            SZ_W:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] base_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 4'b0001;
            SZ_H:    return 4'b0011;
            SZ_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extract.sv
// Shifts a two-word load window down by the lane offset and sign/zero-extends to size.
// Latency: combinational.
// Backpressure: none.
module lsu_extract
    import lsu_pkg::*;
(
    input  logic [63:0] dword,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    assign shifted = 32'(dword >> {off, 3'b000});

    always_comb begin
        rdata = '0;
        case (size)
            SZ_B:    rdata = {{24{~uns & shifted[7]}}, shifted[7:0]};
            SZ_H:    rdata = {{16{~uns & shifted[15]}}, shifted[15:0]};
            SZ_W:    rdata = shifted;
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment: byte-addressed requests to word-addressed memory cycles, splitting word-crossing accesses.
// Latency: accept edge to resp_valid 2 cycles (aligned), 3 (crossing), 1 (rejected).
// Backpressure: req_ready only in IDLE; one request in flight, no queuing.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int MISALIGN_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_waddr,
    output logic [3:0]        mem_wmask,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t            state_q, state_d;
    req_t              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic [31:0]       word0_q, word1_q;

    logic [1:0]        off;
    logic [ADDR_W-3:0] word_addr;
    logic              in_cross, in_err, cross_q;
    logic [7:0]        mask8;
    logic [63:0]       wdata64;
    logic              acc0, acc1;
    logic [31:0]       ext_rdata;

    assign off       = addr_q[1:0];
    assign word_addr = addr_q[ADDR_W-1:2];

    // Crossing test on the incoming request decides rejection before any memory cycle.
    assign in_cross = ({2'b00, req_addr[1:0]} + {1'b0, size_bytes(req_size)}) > 4'd4;
    assign in_err   = (req_size == 2'b11) || (in_cross && (MISALIGN_EN == 0));
    assign cross_q  = ({2'b00, off} + {1'b0, size_bytes(req_q.size)}) > 4'd4;

    // Low nibble is the first word's lanes, high nibble spills into the next word.
    assign mask8   = {4'b0000, base_mask(req_q.size)} << off;
    assign wdata64 = {32'h0, req_q.wdata} << {off, 3'b000};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = in_err ? ST_RESP : ST_ACC0;
            ST_ACC0: state_d = cross_q ? ST_ACC1 : ST_RESP;
            ST_ACC1: state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign acc0 = (state_q == ST_ACC0);
    assign acc1 = (state_q == ST_ACC1);

    // Reset suppresses the access in the same cycle so an aborted split store leaves its second word untouched.
    always_comb begin
        mem_en    = (acc0 || acc1) && !rst;
        mem_we    = mem_en && req_q.we;
        mem_waddr = acc1 ? word_addr + (ADDR_W-2)'(1) : word_addr;
        mem_wmask = 4'b0000;
        if (mem_we) mem_wmask = acc1 ? mask8[7:4] : mask8[3:0];
        mem_wdata = acc1 ? wdata64[63:32] : wdata64[31:0];
    end

    lsu_extract u_extract (
        .dword (acc1 ? {mem_rdata, word0_q} : {word1_q, word0_q}),
        .off   (off),
        .size  (req_q.size),
        .uns   (req_q.uns),
        .rdata (ext_rdata)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !err_q && !req_q.we) ? ext_rdata : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && req_valid) begin
                req_q.we    <= req_we;
                req_q.size  <= req_size;
                req_q.uns   <= req_unsigned;
                req_q.wdata <= req_wdata;
                addr_q      <= req_addr;
                err_q       <= in_err;
            end
            if (acc0) word0_q <= mem_rdata;
            if (acc1) word1_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// Scoreboard bench for lsu_align: directed requests push expected responses and memory accesses; monitors pop and compare.
module tb_lsu_align;
    import lsu_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } resp_exp_t;

    typedef struct {
        logic        we;
        logic [29:0] waddr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } acc_exp_t;

    logic        clk = 1'b0;
    logic        rst, preload;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_en, mem_we;
    logic [29:0] mem_waddr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata, mem_rdata;

    logic        nm_req_valid, nm_req_we, nm_req_unsigned;
    logic [1:0]  nm_req_size;
    logic [31:0] nm_req_addr, nm_req_wdata;
    logic        nm_req_ready, nm_resp_valid, nm_resp_err;
    logic [31:0] nm_resp_rdata;
    logic        nm_mem_en, nm_mem_we;
    logic [29:0] nm_mem_waddr;
    logic [3:0]  nm_mem_wmask;
    logic [31:0] nm_mem_wdata;
    logic [31:0] nm_mem_rdata;
    int          nm_acc_cnt = 0;

    logic [31:0] mem [0:15];
    resp_exp_t   resp_q[$];
    resp_exp_t   nm_resp_q[$];
    acc_exp_t    acc_q[$];
    resp_exp_t   re, nre;
    acc_exp_t    ae;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_align #(.ADDR_W(32), .MISALIGN_EN(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_en(mem_en), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    lsu_align #(.ADDR_W(32), .MISALIGN_EN(0)) dut_nm (
        .clk(clk), .rst(rst),
        .req_valid(nm_req_valid), .req_ready(nm_req_ready), .req_we(nm_req_we),
        .req_size(nm_req_size), .req_unsigned(nm_req_unsigned), .req_addr(nm_req_addr),
        .req_wdata(nm_req_wdata), .resp_valid(nm_resp_valid), .resp_rdata(nm_resp_rdata),
        .resp_err(nm_resp_err), .mem_en(nm_mem_en), .mem_we(nm_mem_we),
        .mem_waddr(nm_mem_waddr), .mem_wmask(nm_mem_wmask), .mem_wdata(nm_mem_wdata),
        .mem_rdata(nm_mem_rdata)
    );

    // Data_Memory model: combinational read, masked byte writes on the clock edge.
    assign mem_rdata    = mem[mem_waddr[3:0]];
    assign nm_mem_rdata = 32'h13579BDF;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h44332211;
            mem[5] <= 32'h88776655;
            mem[6] <= 32'hCAFEF00D;
        end else if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) mem[mem_waddr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (resp_q.size() == 0) begin
                check("resp_unexpected", resp_valid, 0);
            end else begin
                re = resp_q.pop_front();
                check("resp_rdata", resp_rdata, re.rdata);
                check("resp_err", resp_err, re.err);
                check("resp_latency_cyc", cyc, re.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (mem_en === 1'b1) begin
            if (acc_q.size() == 0) begin
                check("mem_unexpected", mem_en, 0);
            end else begin
                ae = acc_q.pop_front();
                check("mem_we", mem_we, ae.we);
                check("mem_waddr", mem_waddr, ae.waddr);
                check("mem_wmask", mem_wmask, ae.wmask);
                if (ae.we) check("mem_wdata", mem_wdata, ae.wdata);
            end
        end
    end

    always @(negedge clk) begin
        if (nm_mem_en === 1'b1) nm_acc_cnt <= nm_acc_cnt + 1;
        if (nm_resp_valid === 1'b1) begin
            if (nm_resp_q.size() == 0) begin
                check("nm_resp_unexpected", nm_resp_valid, 0);
            end else begin
                nre = nm_resp_q.pop_front();
                check("nm_resp_rdata", nm_resp_rdata, nre.rdata);
                check("nm_resp_err", nm_resp_err, nre.err);
                check("nm_resp_latency_cyc", cyc, nre.cyc);
            end
        end
    end

    task automatic push_acc(input logic we, input logic [29:0] waddr, input logic [3:0] wmask,
                            input logic [31:0] wdata);
        acc_exp_t e;
        e.we = we; e.waddr = waddr; e.wmask = wmask; e.wdata = wdata;
        acc_q.push_back(e);
    endtask

    // Called at posedge+1; returns one cycle after the accept edge with the expected response queued.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                         input int lat, input logic push);
        resp_exp_t e;
        int waited = 0;
        while (!req_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("req_ready_wait", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_size = 2'b11; req_wdata = 32'h5555_5555;
        e.rdata = exp_rdata; e.err = exp_err; e.cyc = cyc + lat - 1;
        if (push) resp_q.push_back(e);
    endtask

    task automatic issue_nm(input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] exp_rdata, input logic exp_err, input int lat);
        resp_exp_t e;
        int waited = 0;
        while (!nm_req_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("nm_req_ready_wait", nm_req_ready, 1);
        nm_req_valid = 1'b1; nm_req_we = 1'b0; nm_req_size = size; nm_req_unsigned = 1'b0;
        nm_req_addr = addr; nm_req_wdata = 32'h0;
        @(posedge clk); #1;
        nm_req_valid = 1'b0;
        e.rdata = exp_rdata; e.err = exp_err; e.cyc = cyc + lat - 1;
        nm_resp_q.push_back(e);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; preload = 1'b1;
        req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
        nm_req_valid = 0; nm_req_we = 0; nm_req_size = 0; nm_req_unsigned = 0;
        nm_req_addr = 0; nm_req_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_wmask", mem_wmask, 0);
        preload = 1'b0; rst = 1'b0;
        @(posedge clk); #1;

        // Loads against the preloaded words.
        push_acc(0, 30'h4, 4'b0000, 32'h0);
        issue(0, SZ_W, 0, 32'h10, 0, 32'h44332211, 0, 2, 1);
        push_acc(0, 30'h4, 4'b0000, 32'h0); push_acc(0, 30'h5, 4'b0000, 32'h0);
        issue(0, SZ_W, 0, 32'h12, 0, 32'h66554433, 0, 3, 1);
        push_acc(0, 30'h5, 4'b0000, 32'h0);
        issue(0, SZ_B, 0, 32'h17, 0, 32'hFFFFFF88, 0, 2, 1);
        push_acc(0, 30'h5, 4'b0000, 32'h0);
        issue(0, SZ_B, 1, 32'h17, 0, 32'h00000088, 0, 2, 1);
        push_acc(0, 30'h4, 4'b0000, 32'h0); push_acc(0, 30'h5, 4'b0000, 32'h0);
        issue(0, SZ_H, 0, 32'h13, 0, 32'h00005544, 0, 3, 1);
        push_acc(0, 30'h5, 4'b0000, 32'h0);
        issue(0, SZ_H, 0, 32'h16, 0, 32'hFFFF8877, 0, 2, 1);

        // Crossing half store, then reread both words.
        push_acc(1, 30'h4, 4'b1000, 32'hCD000000); push_acc(1, 30'h5, 4'b0001, 32'h000000AB);
        issue(1, SZ_H, 0, 32'h13, 32'h0000ABCD, 32'h0, 0, 3, 1);
        push_acc(0, 30'h4, 4'b0000, 32'h0);
        issue(0, SZ_W, 0, 32'h10, 0, 32'hCD332211, 0, 2, 1);
        push_acc(0, 30'h5, 4'b0000, 32'h0);
        issue(0, SZ_W, 0, 32'h14, 0, 32'h887766AB, 0, 2, 1);

        // Byte store into lane 1.
        push_acc(1, 30'h4, 4'b0010, 32'h00005A00);
        issue(1, SZ_B, 0, 32'h11, 32'h0000005A, 32'h0, 0, 2, 1);
        push_acc(0, 30'h4, 4'b0000, 32'h0);
        issue(0, SZ_W, 0, 32'h10, 0, 32'hCD335A11, 0, 2, 1);

        // Illegal size: error response, no memory cycle.
        issue(0, 2'b11, 0, 32'h10, 0, 32'h0, 1, 1, 1);
        issue(1, 2'b11, 0, 32'h13, 32'h1234, 32'h0, 1, 1, 1);

        // Misalignment disabled: crossing rejected, in-word accesses still served.
        issue_nm(SZ_W, 32'h11, 32'h0, 1, 1);
        issue_nm(SZ_H, 32'h13, 32'h0, 1, 1);
        issue_nm(SZ_W, 32'h10, 32'h13579BDF, 0, 2);
        issue_nm(SZ_H, 32'h12, 32'h00001357, 0, 2);

        // Reset during the second half of a crossing store.
        push_acc(1, 30'h5, 4'b1100, 32'hBEEF0000);
        issue(1, SZ_W, 0, 32'h16, 32'hDEADBEEF, 32'h0, 0, 3, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_req_ready", req_ready, 1);
        check("abort_resp_valid", resp_valid, 0);
        check("abort_mem_en", mem_en, 0);
        check("abort_word5", mem[5], 32'hBEEF66AB);
        check("abort_word6", mem[6], 32'hCAFEF00D);
        repeat (5) @(posedge clk);
        #1;

        for (int i = 0; i < 50 && (resp_q.size() != 0 || nm_resp_q.size() != 0 || acc_q.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        check("resp_q_drained", resp_q.size(), 0);
        check("nm_resp_q_drained", nm_resp_q.size(), 0);
        check("acc_q_drained", acc_q.size(), 0);
        check("nm_mem_access_count", nm_acc_cnt, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
